id_ex_alu_dec: RTL and testbench
================================

// Module: id_ex_alu_dec
// PURPOSE
//  ID-side producer for the EX-stage ALU interface. Decodes one RV32I instruction into
//  alu_op, alu_src1 and alu_src2, plus branch, memory and writeback controls.
//  Registers the result as the ID/EX pipeline register, with a valid/ready handshake and flush.
//  Sits between the register file read and the alu/branch logic in EX.
// PARAMETERS
//  XLEN      32  datapath width; must equal `CPU_WIDTH
//  RST_INST  32'h0000_0013  value held in the out_inst register after reset/flush (ADDI x0,x0,0)
// PORTS
//  clk           in   1              clock; all state updates on posedge
//  rst           in   1              synchronous, active-high reset
//  flush         in   1              kill the held entry (branch taken / trap)
//  in_valid      in   1              ID presents an instruction
//  in_ready      out  1              ID/EX register can accept
//  in_inst       in   32             raw instruction
//  in_pc         in   XLEN           pc of in_inst
//  in_rs1_data   in   XLEN           regfile rs1 value (already forwarded)
//  in_rs2_data   in   XLEN           regfile rs2 value (already forwarded)
//  out_valid     out  1              EX entry valid
//  out_ready     in   1              EX consumes entry this cycle
//  out_alu_op    out  ALU_OP_WIDTH   alu opcode (`ALU_* codes)
//  out_alu_src1  out  XLEN           alu operand 1
//  out_alu_src2  out  XLEN           alu operand 2
//  out_imm       out  XLEN           sign-extended immediate (branch/jump/mem offset)
//  out_pc        out  XLEN           pc of entry
//  out_st_data   out  XLEN           rs2 value for stores
//  out_rd_idx    out  5              destination register
//  out_rd_we     out  1              writeback enable
//  out_mem_re    out  1              load
//  out_mem_we    out  1              store
//  out_br_type   out  3              0 none, 1 br-if-zero, 2 br-if-nonzero, 3 jal, 4 jalr
//  out_illegal   out  1              undecodable instruction
//  out_inst      out  32             registered instruction (carries funct3 to mem/EX)
// BEHAVIOUR
//  - Reset: out_valid=0; out_inst=RST_INST; every other registered output=0.
//  - in_ready = !out_valid | out_ready (combinational). Load when in_valid & in_ready.
//  - Latency is 1 cycle from accept to out_valid=1.
//  - Held outputs are stable while out_valid & !out_ready.
//  - Without a new accept, out_ready drops out_valid to 0 on the next edge.
//  - flush: next edge out_valid=0 and out_inst=RST_INST, even if in_valid & in_ready in the same
//    cycle. flush wins over load; the ID instruction is dropped. rst wins over flush.
//  - Decode by opcode:
//    OP      src1=rs1, src2=rs2. funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
//    OP-IMM  src2=I-imm. SLLI/SRLI need imm[11:5]=0; SRAI needs imm[11:5]=0100000.
//    LUI     src1=0, src2=U-imm, ADD.      AUIPC  src1=pc, src2=U-imm, ADD.
//    JAL     src1=pc, src2=4, ADD, br_type=3, imm=J-imm (link value from the ALU).
//    JALR    src1=pc, src2=4, ADD, br_type=4, imm=I-imm; funct3 must be 0.
//    BRANCH  src1=rs1, src2=rs2, rd_we=0, imm=B-imm:
//            BEQ  SUB,  type 1     BNE  SUB,  type 2
//            BLT  SLT,  type 2     BGE  SLT,  type 1
//            BLTU SLTU, type 2     BGEU SLTU, type 1
//            funct3 010/011 are illegal.
//    LOAD    ADD rs1+I-imm, mem_re=1; funct3 in {000,001,010,100,101}.
//    STORE   ADD rs1+S-imm, mem_we=1, rd_we=0, st_data=rs2; funct3 in {000,001,010}.
//  - OP funct7 other than 0000000 (or 0100000 for ADD/SUB and SRL/SRA) is illegal.
//  - Illegal: out_illegal=1, alu_op=`ALU_ADD, rd_we=mem_re=mem_we=0, br_type=0.
//  - Illegal covers unknown opcode, inst[1:0]!=11 and FENCE/SYSTEM (not supported here).
//  - rd_we forced 0 when rd_idx==0. All immediates sign-extend from inst[31].
// STRUCTURE
//  - Add to rvseed_defines.v: opcode constants, BR_* type codes and the funct7 constants.
//    Reuse the existing `ALU_* codes and widths.
//  - One sub-module, alu_ctrl_dec: purely combinational inst/pc/rs data -> control bundle.
//  - The top holds only the handshake and the pipeline register.
// TESTING
//  - ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op=ADD,
//    src1=5, src2=7, rd=3, rd_we=1.
//  - SRAI x1,x2,4 (0x40415093) -> op=SRA, src2=4.
//    imm[11:5]=0100001 -> out_illegal=1, rd_we=0.
//  - BGE with rs1=-1, rs2=1 -> op=SLT, br_type=1. BLTU -> op=SLTU, br_type=2.
//    B-imm of 0x8F0-form sign-extends correctly.
//  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs held.
//    out_ready=1 -> next inst loaded the same edge with no bubble.
//  - flush and a valid accept in the same cycle -> out_valid=0 next cycle, out_inst=0x00000013.
//    The following accept proceeds normally.
//  - rst asserted mid-stall -> all outputs at reset values next edge; in_ready=1.

Source files
------------

// File: rtl/id_ex_alu_dec_pkg.sv
// Shared types and constants for the ID/EX ALU decode slice: ALU op codes,
// RV32I opcodes, branch-type codes and the decoded control bundle.
package id_ex_alu_dec_pkg;

  localparam int XLEN         = 32;
  localparam int ALU_OP_WIDTH = 4;

  // ALU operation codes consumed by the EX-stage ALU
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;

  // Full 7-bit opcodes; the low two bits must be 11 for any legal RV32I word
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Branch types: Z/NZ test the ALU result against zero in EX
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_Z    = 3'd1;
  localparam logic [2:0] BR_NZ   = 3'd2;
  localparam logic [2:0] BR_JAL  = 3'd3;
  localparam logic [2:0] BR_JALR = 3'd4;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [XLEN-1:0]         alu_src1;
    logic [XLEN-1:0]         alu_src2;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         st_data;
    logic [4:0]              rd_idx;
    logic                    rd_we;
    logic                    mem_re;
    logic                    mem_we;
    logic [2:0]              br_type;
    logic                    illegal;
  } alu_ctrl_t;

  // funct3 -> ALU op for the non-alternate forms of OP / OP-IMM
  function automatic logic [ALU_OP_WIDTH-1:0] base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder: instruction, pc and register operands in,
// ALU/branch/memory/writeback control bundle out.
module alu_ctrl_dec
  import id_ex_alu_dec_pkg::*;
(
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output alu_ctrl_t       ctrl
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;
  logic            legal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign shamt = {27'b0, inst[24:20]};

  // Opcode decode; any illegal encoding collapses to a harmless ADD with no side effects
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    ctrl.rd_idx = inst[11:7];
    legal       = 1'b1;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_src1 = rs1_data;
        ctrl.alu_src2 = rs2_data;
        ctrl.rd_we    = 1'b1;
        if (funct7 == F7_ZERO)                         ctrl.alu_op = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) ctrl.alu_op = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) ctrl.alu_op = ALU_SRA;
        else                                           legal = 1'b0;
      end
      OPC_OP_IMM: begin
        ctrl.alu_src1 = rs1_data;
        ctrl.alu_src2 = imm_i;
        ctrl.imm      = imm_i;
        ctrl.rd_we    = 1'b1;
        ctrl.alu_op   = base_op(funct3);
        // Shifts take the 5-bit shamt; the upper imm bits select the shift kind
        if (funct3 == 3'b001) begin
          ctrl.alu_src2 = shamt;
          if (funct7 != F7_ZERO) legal = 1'b0;
        end else if (funct3 == 3'b101) begin
          ctrl.alu_src2 = shamt;
          if (funct7 == F7_ALT)       ctrl.alu_op = ALU_SRA;
          else if (funct7 != F7_ZERO) legal = 1'b0;
        end
      end
      OPC_LUI: begin
        ctrl.alu_src2 = imm_u;
        ctrl.imm      = imm_u;
        ctrl.rd_we    = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.alu_src1 = pc;
        ctrl.alu_src2 = imm_u;
        ctrl.imm      = imm_u;
        ctrl.rd_we    = 1'b1;
      end
      OPC_JAL: begin
        ctrl.alu_src1 = pc;
        ctrl.alu_src2 = 32'd4;
        ctrl.imm      = imm_j;
        ctrl.rd_we    = 1'b1;
        ctrl.br_type  = BR_JAL;
      end
      OPC_JALR: begin
        ctrl.alu_src1 = pc;
        ctrl.alu_src2 = 32'd4;
        ctrl.imm      = imm_i;
        ctrl.rd_we    = 1'b1;
        ctrl.br_type  = BR_JALR;
        legal         = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.alu_src1 = rs1_data;
        ctrl.alu_src2 = rs2_data;
        ctrl.imm      = imm_b;
        case (funct3)
          3'b000:  begin ctrl.alu_op = ALU_SUB;  ctrl.br_type = BR_Z;  end
          3'b001:  begin ctrl.alu_op = ALU_SUB;  ctrl.br_type = BR_NZ; end
          3'b100:  begin ctrl.alu_op = ALU_SLT;  ctrl.br_type = BR_NZ; end
          3'b101:  begin ctrl.alu_op = ALU_SLT;  ctrl.br_type = BR_Z;  end
          3'b110:  begin ctrl.alu_op = ALU_SLTU; ctrl.br_type = BR_NZ; end
          3'b111:  begin ctrl.alu_op = ALU_SLTU; ctrl.br_type = BR_Z;  end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        ctrl.alu_src1 = rs1_data;
        ctrl.alu_src2 = imm_i;
        ctrl.imm      = imm_i;
        ctrl.mem_re   = 1'b1;
        ctrl.rd_we    = 1'b1;
        legal         = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        ctrl.alu_src1 = rs1_data;
        ctrl.alu_src2 = imm_s;
        ctrl.imm      = imm_s;
        ctrl.st_data  = rs2_data;
        ctrl.mem_we   = 1'b1;
        legal         = (funct3[2] == 1'b0) && (funct3 != 3'b011);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.alu_op  = ALU_ADD;
      ctrl.rd_idx  = inst[11:7];
      ctrl.illegal = 1'b1;
    end else if (ctrl.rd_idx == 5'd0) begin
      ctrl.rd_we = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_alu_dec.sv
// ID/EX pipeline register for the ALU interface: decodes the ID instruction
// and holds the result for EX under a valid/ready handshake with flush.
module id_ex_alu_dec
  import id_ex_alu_dec_pkg::*;
#(
  parameter logic [31:0] RST_INST = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_rs1_data,
  input  logic [XLEN-1:0]         in_rs2_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALU_OP_WIDTH-1:0] out_alu_op,
  output logic [XLEN-1:0]         out_alu_src1,
  output logic [XLEN-1:0]         out_alu_src2,
  output logic [XLEN-1:0]         out_imm,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_st_data,
  output logic [4:0]              out_rd_idx,
  output logic                    out_rd_we,
  output logic                    out_mem_re,
  output logic                    out_mem_we,
  output logic [2:0]              out_br_type,
  output logic                    out_illegal,
  output logic [31:0]             out_inst
);

  alu_ctrl_t dec_ctrl;
  alu_ctrl_t ctrl_q;

  alu_ctrl_dec u_dec (
    .inst     (in_inst),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .ctrl     (dec_ctrl)
  );

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // valid never waits on ready, and a held entry stays stable until it is taken.
  // The register frees up either when empty or when EX takes the entry this cycle.
  assign in_ready = !out_valid || out_ready;

  // Pipeline register: rst beats flush, flush beats load, load beats drain
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_inst  <= RST_INST;
      out_pc    <= '0;
      ctrl_q    <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_inst  <= in_inst;
      out_pc    <= in_pc;
      ctrl_q    <= dec_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_alu_op   = ctrl_q.alu_op;
  assign out_alu_src1 = ctrl_q.alu_src1;
  assign out_alu_src2 = ctrl_q.alu_src2;
  assign out_imm      = ctrl_q.imm;
  assign out_st_data  = ctrl_q.st_data;
  assign out_rd_idx   = ctrl_q.rd_idx;
  assign out_rd_we    = ctrl_q.rd_we;
  assign out_mem_re   = ctrl_q.mem_re;
  assign out_mem_we   = ctrl_q.mem_we;
  assign out_br_type  = ctrl_q.br_type;
  assign out_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_dec.sv
// Bench for id_ex_alu_dec: instruction-level reference model plus directed
// vectors with hand-computed expectations.
module tb_id_ex_alu_dec;
  import id_ex_alu_dec_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, in_rs1_data, in_rs2_data;
  logic [3:0]  out_alu_op;
  logic [31:0] out_alu_src1, out_alu_src2, out_imm, out_pc, out_st_data, out_inst;
  logic [4:0]  out_rd_idx;
  logic        out_rd_we, out_mem_re, out_mem_we, out_illegal;
  logic [2:0]  out_br_type;

  id_ex_alu_dec dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
    .out_imm(out_imm), .out_pc(out_pc), .out_st_data(out_st_data),
    .out_rd_idx(out_rd_idx), .out_rd_we(out_rd_we),
    .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_br_type(out_br_type), .out_illegal(out_illegal), .out_inst(out_inst)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] s1, s2, imm, st;
    logic [4:0]  rd;
    logic        we, re, wr;
    logic [2:0]  br;
    logic        ill;
  } exp_t;

  // Instruction-set view: classify by opcode, look up funct3 tables, compute
  // immediates as signed integers.
  function automatic exp_t model(input logic [31:0] inst, pc, a, b);
    exp_t        e;
    logic [3:0]  f3op [8]  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [3:0]  brop [8]  = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
    logic [2:0]  brty [8]  = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd2, 3'd1, 3'd2, 3'd1};
    logic [7:0]  br_ok     = 8'b1111_0011;
    logic [7:0]  ld_ok     = 8'b0011_0111;
    logic [7:0]  st_ok     = 8'b0000_0111;
    logic [2:0]  f3  = inst[14:12];
    logic [6:0]  f7  = inst[31:25];
    int          ii  = $signed(inst[31:20]);
    int          si  = $signed({inst[31:25], inst[11:7]});
    int          bi  = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    int          ji  = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    int          ui  = inst[31:12] * 4096;
    int          sh  = inst[24:20];
    bit          ok  = 1'b1;
    e = '0;
    e.op = ALU_ADD;
    e.rd = inst[11:7];
    case (inst[6:0])
      7'h33: begin
        e.s1 = a; e.s2 = b; e.we = 1'b1;
        if (f7 == 7'h00) e.op = f3op[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_SRA;
        else ok = 1'b0;
      end
      7'h13: begin
        e.s1 = a; e.imm = ii; e.we = 1'b1; e.op = f3op[f3];
        e.s2 = (f3 == 3'd1 || f3 == 3'd5) ? sh : ii;
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_SRA;
        else if (f3 == 3'd5 && f7 != 7'h00) ok = 1'b0;
      end
      7'h37: begin e.s2 = ui; e.imm = ui; e.we = 1'b1; end
      7'h17: begin e.s1 = pc; e.s2 = ui; e.imm = ui; e.we = 1'b1; end
      7'h6F: begin e.s1 = pc; e.s2 = 4; e.imm = ji; e.we = 1'b1; e.br = 3'd3; end
      7'h67: begin e.s1 = pc; e.s2 = 4; e.imm = ii; e.we = 1'b1; e.br = 3'd4; ok = (f3 == 3'd0); end
      7'h63: begin e.s1 = a; e.s2 = b; e.imm = bi; e.op = brop[f3]; e.br = brty[f3]; ok = br_ok[f3]; end
      7'h03: begin e.s1 = a; e.s2 = ii; e.imm = ii; e.re = 1'b1; e.we = 1'b1; ok = ld_ok[f3]; end
      7'h23: begin e.s1 = a; e.s2 = si; e.imm = si; e.st = b; e.wr = 1'b1; ok = st_ok[f3]; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0; e.op = ALU_ADD; e.rd = inst[11:7]; e.ill = 1'b1;
    end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  // Model of the register slot, stepped on every clock edge from the bench inputs
  logic        m_valid;
  exp_t        m_e;
  logic [31:0] m_pc, m_inst;

  always @(posedge clk) begin
    if (rst || flush) begin
      m_valid <= 1'b0; m_e <= '0; m_pc <= '0; m_inst <= 32'h0000_0013;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1; m_e <= model(in_inst, in_pc, in_rs1_data, in_rs2_data);
      m_pc <= in_pc; m_inst <= in_inst;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: every cycle, on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_inst", out_inst, m_inst);
      chk("out_pc", out_pc, m_pc);
      chk("out_alu_op", out_alu_op, m_e.op);
      chk("out_alu_src1", out_alu_src1, m_e.s1);
      chk("out_alu_src2", out_alu_src2, m_e.s2);
      chk("out_imm", out_imm, m_e.imm);
      chk("out_st_data", out_st_data, m_e.st);
      chk("out_rd_idx", out_rd_idx, m_e.rd);
      chk("out_rd_we", out_rd_we, m_e.we);
      chk("out_mem_re", out_mem_re, m_e.re);
      chk("out_mem_we", out_mem_we, m_e.wr);
      chk("out_br_type", out_br_type, m_e.br);
      chk("out_illegal", out_illegal, m_e.ill);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b);
    in_valid = 1'b1; in_inst = i; in_pc = p; in_rs1_data = a; in_rs2_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Encodings used below
  localparam logic [31:0] I_ADD      = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB      = 32'h4073_02B3; // sub  x5,x6,x7
  localparam logic [31:0] I_SRAI     = 32'h4041_5093; // srai x1,x2,4
  localparam logic [31:0] I_SRAI_BAD = 32'h4241_5093; // imm[11:5]=0100001
  localparam logic [31:0] I_BGE      = 32'h8E20_D8E3; // bge  x1,x2,-0x710
  localparam logic [31:0] I_BLTU     = 32'h8E20_E8E3; // bltu x1,x2,-0x710
  localparam logic [31:0] I_BR_BAD   = 32'h8E20_A8E3; // branch funct3=010
  localparam logic [31:0] I_LUI      = 32'h1234_5237; // lui  x4,0x12345
  localparam logic [31:0] I_AUIPC    = 32'hFFFF_F317; // auipc x6,0xfffff
  localparam logic [31:0] I_JAL      = 32'h0080_00EF; // jal  x1,+8
  localparam logic [31:0] I_JALR     = 32'h00C2_80E7; // jalr x1,12(x5)
  localparam logic [31:0] I_JALR_BAD = 32'h00C2_90E7; // jalr funct3=001
  localparam logic [31:0] I_LW       = 32'hFFC1_2383; // lw   x7,-4(x2)
  localparam logic [31:0] I_LD_BAD   = 32'hFFC1_3383; // load funct3=011
  localparam logic [31:0] I_SW       = 32'h0020_A423; // sw   x2,8(x1)
  localparam logic [31:0] I_ADDI_X0  = 32'h0050_0013; // addi x0,x0,5
  localparam logic [31:0] I_MUL      = 32'h0220_81B3; // funct7=0000001
  localparam logic [31:0] I_FENCE    = 32'h0000_000F;
  localparam logic [31:0] I_ECALL    = 32'h0000_0073;

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] extra [10];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Reset values
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_inst", out_inst, 32'h0000_0013);
    chk("rst out_alu_src1", out_alu_src1, 0);
    chk("rst out_rd_we", out_rd_we, 0);
    rst = 1'b0;

    // Directed decodes with literal expectations
    send(I_ADD, 32'h100, 32'd5, 32'd7);
    chk("add valid", out_valid, 1);
    chk("add op", out_alu_op, ALU_ADD);
    chk("add src1", out_alu_src1, 5);
    chk("add src2", out_alu_src2, 7);
    chk("add rd", out_rd_idx, 3);
    chk("add rd_we", out_rd_we, 1);

    send(I_SRAI, 32'h104, 32'h8000_0000, 32'd0);
    chk("srai op", out_alu_op, ALU_SRA);
    chk("srai src2", out_alu_src2, 4);
    chk("srai illegal", out_illegal, 0);

    send(I_SRAI_BAD, 32'h108, 32'd1, 32'd2);
    chk("srai_bad illegal", out_illegal, 1);
    chk("srai_bad rd_we", out_rd_we, 0);
    chk("srai_bad op", out_alu_op, ALU_ADD);

    send(I_BGE, 32'h200, 32'hFFFF_FFFF, 32'd1);
    chk("bge op", out_alu_op, ALU_SLT);
    chk("bge br_type", out_br_type, 1);
    chk("bge imm", out_imm, 32'hFFFF_F8F0);
    chk("bge rd_we", out_rd_we, 0);
    chk("bge src1", out_alu_src1, 32'hFFFF_FFFF);

    send(I_BLTU, 32'h204, 32'd3, 32'd9);
    chk("bltu op", out_alu_op, ALU_SLTU);
    chk("bltu br_type", out_br_type, 2);

    send(I_LW, 32'h208, 32'h1000, 32'd0);
    chk("lw src2", out_alu_src2, 32'hFFFF_FFFC);
    chk("lw mem_re", out_mem_re, 1);
    chk("lw rd", out_rd_idx, 7);

    send(I_SW, 32'h20C, 32'h2000, 32'hCAFE_F00D);
    chk("sw mem_we", out_mem_we, 1);
    chk("sw rd_we", out_rd_we, 0);
    chk("sw st_data", out_st_data, 32'hCAFE_F00D);
    chk("sw src2", out_alu_src2, 8);

    send(I_JAL, 32'h300, 32'd0, 32'd0);
    chk("jal src1", out_alu_src1, 32'h300);
    chk("jal src2", out_alu_src2, 4);
    chk("jal br_type", out_br_type, 3);
    chk("jal imm", out_imm, 8);

    send(I_ADDI_X0, 32'h304, 32'd0, 32'd0);
    chk("addi_x0 rd_we", out_rd_we, 0);

    send(I_FENCE, 32'h308, 32'd0, 32'd0);
    chk("fence illegal", out_illegal, 1);

    // Remaining encodings back-to-back, checked by the model only
    extra = '{I_SUB, I_LUI, I_AUIPC, I_JALR, I_JALR_BAD, I_LD_BAD, I_BR_BAD,
              I_MUL, I_ECALL, 32'h0000_0000};
    foreach (extra[k])
      send(extra[k], 32'h400 + 4 * k, $urandom, $urandom_range(0, 255));
    idle(1);

    // Back-pressure: entry held while EX stalls, next one loads with no bubble
    out_ready = 1'b0;
    send(I_ADD, 32'h500, 32'd1, 32'd2);
    in_valid = 1'b1; in_inst = I_SUB; in_pc = 32'h504; in_rs1_data = 32'd10; in_rs2_data = 32'd3;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall in_ready", in_ready, 0);
      chk("stall inst held", out_inst, I_ADD);
      chk("stall src1 held", out_alu_src1, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("unstall inst", out_inst, I_SUB);
    chk("unstall valid", out_valid, 1);
    chk("unstall op", out_alu_op, ALU_SUB);
    in_valid = 1'b0;
    idle(1);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    send(I_LUI, 32'h600, 32'd0, 32'd0);
    in_valid = 1'b1; in_inst = I_AUIPC; in_pc = 32'h604;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_stall valid", out_valid, 0);
    chk("rst_stall in_ready", in_ready, 1);
    chk("rst_stall inst", out_inst, 32'h0000_0013);
    chk("rst_stall src2", out_alu_src2, 0);
    out_ready = 1'b1;

    // Flush wins over a same-cycle accept; the following accept is normal
    flush = 1'b1;
    send(I_ADD, 32'h700, 32'd5, 32'd7);
    flush = 1'b0;
    chk("flush valid", out_valid, 0);
    chk("flush inst", out_inst, 32'h0000_0013);
    send(I_ADD, 32'h704, 32'd5, 32'd7);
    chk("post_flush valid", out_valid, 1);
    chk("post_flush inst", out_inst, I_ADD);
    chk("post_flush pc", out_pc, 32'h704);

    idle(2);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
